gated_add_reg_array: RTL and testbench
======================================

GATED_ADD_REG_ARRAY -- requirements
Module: gated_add_reg_array

Interface
REQ-001 Parameter WIDTH, default 4: bits per lane operand and result.
REQ-002 Parameter LANES, default 2: number of independent lanes.
REQ-003 Parameter SAT, default 0: 0 = wrap-around arithmetic; 1 = saturating unsigned arithmetic.
REQ-004 Parameter CNT_W, default 16: width of the activity counter.
REQ-005 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port clr, input, 1: synchronous clear of results, flags and counter.
REQ-008 Port mode, input, 2: lane operation, shared by all lanes.
REQ-009 Port s, input, LANES: per-lane enable. Bit i gates lane i's register update.
REQ-010 Port x, input, LANES*WIDTH: operand A. Lane i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port y, input, LANES*WIDTH: operand B, with the same packing as x.
REQ-012 Port r, output, LANES*WIDTH: registered lane results, with the same packing as x.
REQ-013 Port ovf, output, LANES: sticky per-lane overflow/underflow flag.
REQ-014 Port busy, output, 1: registered flag, high if any lane updated in the previous cycle.
REQ-015 Port act_cnt, output, CNT_W: count of cycles in which at least one lane was enabled.

Function
REQ-016 Lane i SHALL update r_i only on a rising clk edge with s[i]=1. With s[i]=0, r_i and ovf[i] SHALL hold.
REQ-017 The lane operation SHALL be selected by mode:
- 00: r_i <= x_i + y_i
- 01: r_i <= r_i + x_i (accumulate)
- 10: r_i <= x_i - y_i
- 11: r_i <= r_i (hold even when enabled; no overflow evaluation)
REQ-018 Latency SHALL be one clock: r reflects the inputs sampled at the enabling edge, with no combinational path from inputs to r.
REQ-019 Arithmetic SHALL be unsigned and performed at WIDTH+1 bits. Carry-out (add/accumulate) or borrow (subtract) SHALL mark an overflow event.
REQ-020 On an overflow event with SAT=0, r_i SHALL take the low WIDTH bits (wrap-around).
REQ-021 On an overflow event with SAT=1, r_i SHALL take 2^WIDTH-1 for add/accumulate and 0 for subtract.
REQ-022 An overflow event in an enabled lane SHALL set ovf[i]. Only rst or clr SHALL clear ovf[i].
REQ-023 Lanes SHALL be fully independent: one lane's enable or overflow SHALL have no effect on any other lane.
REQ-024 busy SHALL be registered |(s) when mode != 11, and 0 otherwise.
REQ-025 act_cnt SHALL increment by 1 on each edge where |(s)=1, regardless of mode.
REQ-026 act_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-027 clr=1 at an edge SHALL zero r, ovf, busy and act_cnt. clr SHALL take priority over s and mode on that edge.
REQ-028 Each lane register SHALL be written only through the s-gated enable path, so that synthesis can infer one clock gate per lane.

Reset
REQ-029 rst=1 SHALL immediately force r=0, ovf=0, busy=0 and act_cnt=0, independent of clk.
REQ-030 Assertion of rst mid-operation SHALL discard any in-flight update. The first update after release SHALL occur on the first rising edge with rst=0.
REQ-031 rst SHALL take priority over clr and s.

Verification
REQ-032 The bench SHALL cover the following directed scenarios with WIDTH=4, LANES=2, SAT=0:
- Load/hold: mode=00, lane0 x=1 y=1 s=01 -> next edge r0=2 and r1=0; then x=4 y=3 s=00 -> r0 stays 2 and busy=0.
- Independent lanes: mode=00, lane0 1+3, lane1 4+3, s=11 -> r0=4, r1=7, busy=1, act_cnt increments by 1.
- Wrap: mode=00, x0=15 y0=2 s=01 -> r0=1, ovf[0]=1, ovf[1]=0. ovf[0] stays 1 after a following non-overflowing add.
- Accumulate: r0=0, mode=01, x0=5, s=01 held three edges -> r0 sequence 5, 10, 15. A fourth edge gives r0=4 (wrap) and sets ovf[0].
REQ-033 The bench SHALL also cover these directed scenarios:
- SAT=1: mode=00, 9+9 -> r0=15. mode=10, 2-5 -> r0=0. ovf[0]=1 in both cases.
- Control priority: clr=1 together with s=11 and mode=00 -> r=0, ovf=0, act_cnt=0. Asynchronous rst pulse between edges -> outputs zero before the next edge.

Source files
------------

// File: rtl/gated_add_reg_array.sv
// Purpose : array of independent, individually enabled add/accumulate/subtract lane registers
//           with sticky per-lane overflow flags, a busy flag and a saturating activity counter.
// Latency : one clock from enabling edge to r/ovf/busy/act_cnt; no combinational input-to-output path.
// Backpressure: none; every enabled edge is accepted, s is the only per-lane flow control.
module gated_add_reg_array #(
    parameter int WIDTH = 4,
    parameter int LANES = 2,
    parameter int SAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [1:0]               mode,
    input  logic [LANES-1:0]         s,
    input  logic [LANES*WIDTH-1:0]   x,
    input  logic [LANES*WIDTH-1:0]   y,
    output logic [LANES*WIDTH-1:0]   r,
    output logic [LANES-1:0]         ovf,
    output logic                     busy,
    output logic [CNT_W-1:0]         act_cnt
);

    localparam logic [1:0] M_ADD  = 2'b00;
    localparam logic [1:0] M_ACC  = 2'b01;
    localparam logic [1:0] M_SUB  = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    localparam logic [WIDTH-1:0] LANE_MAX = '1;
    localparam logic [WIDTH-1:0] LANE_MIN = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Any lane enabled this cycle; shared by busy and the activity counter.
    logic any_en;
    assign any_en = |s;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] x_l;
            logic [WIDTH-1:0] y_l;
            logic [WIDTH-1:0] r_q;
            logic             ovf_q;
            logic [WIDTH:0]   op_a;
            logic [WIDTH:0]   op_b;
            logic [WIDTH:0]   sum;
            logic [WIDTH:0]   dif;
            logic [WIDTH-1:0] nxt;
            logic             evt;
            logic             lane_en;

            assign x_l = x[gi*WIDTH +: WIDTH];
            assign y_l = y[gi*WIDTH +: WIDTH];

            // Operand selection and WIDTH+1 bit arithmetic; the extra bit is the carry/borrow.
            always_comb begin
                op_a = {1'b0, x_l};
                op_b = {1'b0, y_l};
                if (mode == M_ACC) begin
                    op_a = {1'b0, r_q};
                    op_b = {1'b0, x_l};
                end
                sum = op_a + op_b;
                dif = op_a - op_b;
            end

            // Next-value and overflow-event selection, with optional clamping.
            always_comb begin
                nxt = r_q;
                evt = 1'b0;
                case (mode)
                    M_ADD, M_ACC: begin
                        evt = sum[WIDTH];
                        nxt = (evt && (SAT != 0)) ? LANE_MAX : sum[WIDTH-1:0];
                    end
                    M_SUB: begin
                        evt = dif[WIDTH];
                        nxt = (evt && (SAT != 0)) ? LANE_MIN : dif[WIDTH-1:0];
                    end
                    M_HOLD: begin
                        evt = 1'b0;
                        nxt = r_q;
                    end
                    default: begin
                        evt = 1'b0;
                        nxt = r_q;
                    end
                endcase
            end

            // Single enable per lane (s or clear) so the register bank maps onto one clock gate.
            assign lane_en = s[gi] | clr;

            // Lane result and sticky overflow; clear wins over the arithmetic update.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q   <= '0;
                    ovf_q <= 1'b0;
                end else if (lane_en) begin
                    if (clr) begin
                        r_q   <= '0;
                        ovf_q <= 1'b0;
                    end else begin
                        r_q   <= nxt;
                        ovf_q <= ovf_q | evt;
                    end
                end
            end

            assign r[gi*WIDTH +: WIDTH] = r_q;
            assign ovf[gi]              = ovf_q;
        end
    endgenerate

    // busy reflects whether any lane actually changed mode-wise on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (clr) begin
            busy <= 1'b0;
        end else begin
            busy <= any_en && (mode != M_HOLD);
        end
    end

    // Activity counter counts enabled cycles in every mode and sticks at its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cnt <= '0;
        end else if (clr) begin
            act_cnt <= '0;
        end else if (any_en && (act_cnt != CNT_MAX)) begin
            act_cnt <= act_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_gated_add_reg_array.sv
// Purpose : checks gated_add_reg_array (wrap and saturating builds) against an integer lane model.
// Latency : model updates on the same edge as the DUT; outputs compared on every falling edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_gated_add_reg_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] s = 2'b00;
    logic [7:0] x = 8'h00;
    logic [7:0] y = 8'h00;

    logic [7:0]  r0, r1;
    logic [1:0]  ovf0, ovf1;
    logic        busy0, busy1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gated_add_reg_array #(.WIDTH(4), .LANES(2), .SAT(0), .CNT_W(16)) dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .s(s), .x(x), .y(y),
        .r(r0), .ovf(ovf0), .busy(busy0), .act_cnt(cnt0)
    );

    gated_add_reg_array #(.WIDTH(4), .LANES(2), .SAT(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode), .s(s), .x(x), .y(y),
        .r(r1), .ovf(ovf1), .busy(busy1), .act_cnt(cnt1)
    );

    // Reference model: index 0 = wrap build, index 1 = saturating build (4-bit counter).
    int mr [2][2];
    bit mo [2][2];
    bit mb [2];
    int mc [2];
    int cmax [2] = '{65535, 15};

    function automatic int opa(int k, int i, logic [1:0] m);
        return (m == 2'd1) ? mr[k][i] : int'(x[i*4 +: 4]);
    endfunction

    function automatic int opb(int i, logic [1:0] m);
        return (m == 2'd1) ? int'(x[i*4 +: 4]) : int'(y[i*4 +: 4]);
    endfunction

    // Exact mathematical result, then decide out-of-range behaviour.
    function automatic int lane_val(int k, int i, logic [1:0] m);
        int v;
        v = (m == 2'd2) ? opa(k, i, m) - opb(i, m) : opa(k, i, m) + opb(i, m);
        if (v > 15) return (k == 1) ? 15 : v - 16;
        if (v < 0)  return (k == 1) ? 0  : v + 16;
        return v;
    endfunction

    function automatic bit lane_ovf(int k, int i, logic [1:0] m);
        int v;
        v = (m == 2'd2) ? opa(k, i, m) - opb(i, m) : opa(k, i, m) + opb(i, m);
        return (v > 15) || (v < 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || clr) begin
                for (int i = 0; i < 2; i++) begin
                    mr[k][i] <= 0;
                    mo[k][i] <= 1'b0;
                end
                mb[k] <= 1'b0;
                mc[k] <= 0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (s[i] && mode != 2'd3) begin
                        mr[k][i] <= lane_val(k, i, mode);
                        mo[k][i] <= mo[k][i] | lane_ovf(k, i, mode);
                    end
                end
                mb[k] <= (s != 2'b00) && (mode != 2'd3);
                if (s != 2'b00 && mc[k] < cmax[k]) mc[k] <= mc[k] + 1;
            end
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                check("model_r_wrap", r0[i*4 +: 4], mr[0][i]);
                check("model_r_sat",  r1[i*4 +: 4], mr[1][i]);
                check("model_ovf_wrap", ovf0[i], mo[0][i]);
                check("model_ovf_sat",  ovf1[i], mo[1][i]);
            end
            check("model_busy_wrap", busy0, mb[0]);
            check("model_busy_sat",  busy1, mb[1]);
            check("model_cnt_wrap",  cnt0, mc[0]);
            check("model_cnt_sat",   cnt1, mc[1]);
        end
    end

    task automatic drive(input logic [1:0] m, input logic [1:0] sv,
                         input int x0, input int y0, input int x1, input int y1);
        logic [3:0] a0, b0, a1, b1;
        a0 = x0[3:0]; b0 = y0[3:0]; a1 = x1[3:0]; b1 = y1[3:0];
        mode = m; s = sv; x = {a1, a0}; y = {b1, b0};
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(2'd0, 2'b00, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #3;
        check("reset_r", r0, 0);
        check("reset_cnt", cnt0, 0);
        check("reset_busy", busy0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Load then hold.
        drive(2'd0, 2'b01, 1, 1, 0, 0);
        step();
        check("load_r0", r0[3:0], 2);
        check("load_r1", r0[7:4], 0);
        drive(2'd0, 2'b00, 4, 3, 0, 0);
        step();
        check("hold_r0", r0[3:0], 2);
        check("hold_busy", busy0, 0);

        // Independent lanes.
        drive(2'd0, 2'b11, 1, 3, 4, 3);
        step();
        check("indep_r0", r0[3:0], 4);
        check("indep_r1", r0[7:4], 7);
        check("indep_busy", busy0, 1);
        check("indep_cnt", cnt0, 2);

        // Wrap and sticky overflow.
        drive(2'd0, 2'b01, 15, 2, 0, 0);
        step();
        check("wrap_r0", r0[3:0], 1);
        check("wrap_ovf0", ovf0[0], 1);
        check("wrap_ovf1", ovf0[1], 0);
        drive(2'd0, 2'b01, 1, 1, 0, 0);
        step();
        check("sticky_ovf0", ovf0[0], 1);

        // Clear has priority over enable and mode.
        clr = 1'b1;
        drive(2'd0, 2'b11, 3, 3, 3, 3);
        step();
        clr = 1'b0;
        check("clr_r", r0, 0);
        check("clr_ovf", ovf0, 0);
        check("clr_cnt", cnt0, 0);

        // Accumulate 5 four times.
        drive(2'd1, 2'b01, 5, 0, 0, 0);
        step(); check("acc1", r0[3:0], 5);
        step(); check("acc2", r0[3:0], 10);
        step(); check("acc3", r0[3:0], 15);
        check("acc3_ovf", ovf0[0], 0);
        step(); check("acc4", r0[3:0], 4);
        check("acc4_ovf", ovf0[0], 1);

        // Saturating build versus wrap build.
        clr = 1'b1; step(); clr = 1'b0;
        drive(2'd0, 2'b01, 9, 9, 0, 0);
        step();
        check("sat_add_r0", r1[3:0], 15);
        check("sat_add_ovf", ovf1[0], 1);
        check("wrap_add_r0", r0[3:0], 2);
        drive(2'd2, 2'b01, 2, 5, 0, 0);
        step();
        check("sat_sub_r0", r1[3:0], 0);
        check("sat_sub_ovf", ovf1[0], 1);
        check("wrap_sub_r0", r0[3:0], 13);

        // Enabled hold mode: result kept, counter still counts, busy low.
        drive(2'd3, 2'b11, 7, 9, 7, 9);
        step();
        check("m11_r0", r0[3:0], 13);
        check("m11_busy", busy0, 0);

        // Asynchronous reset pulse between edges.
        drive(2'd0, 2'b11, 3, 4, 5, 6);
        #1 rst = 1'b1;
        #1;
        check("arst_r", r0, 0);
        check("arst_ovf", ovf1, 0);
        check("arst_cnt", cnt0, 0);
        #1 rst = 1'b0;
        step();
        check("post_rst_r0", r0[3:0], 7);

        // Counter saturation on the 4-bit counter.
        clr = 1'b1; step(); clr = 1'b0;
        drive(2'd3, 2'b01, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++) step();
        check("cnt_sat", cnt1, 15);
        check("cnt_nosat", cnt0, 20);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            clr = ($urandom_range(0, 31) == 0);
            step();
        end
        clr = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
